// File: rtl/alu_exec_seq.sv
// alu_exec_seq: four-state execute sequencer around an external 8-bit ALU.
// Operands and opcode reach the ALU from registers; result and flags are captured before write-back.
module alu_exec_seq #(
  parameter int REG_COUNT = 8,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rs2,
  input  logic              in_imm_en,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_z,
  input  logic              alu_c,
  output logic              done,
  output logic [2:0]        done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int AW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              accept_s;
  logic              ready_r;
  logic              done_r;
  logic [AW-1:0]     done_rd_r;

  logic [2:0]        op_r;
  logic [AW-1:0]     rd_r;
  logic [AW-1:0]     rs1_r;
  logic [AW-1:0]     rs2_r;
  logic              imm_en_r;
  logic [DATA_W-1:0] imm_r;

  logic [DATA_W-1:0] alu_a_r;
  logic [DATA_W-1:0] alu_b_r;
  logic [2:0]        alu_op_r;
  logic [DATA_W-1:0] res_r;
  logic              cz_r;
  logic              cc_r;
  logic              flag_z_r;
  logic              flag_c_r;

  logic [DATA_W-1:0] rf_r [REG_COUNT];

  assign accept_s = in_valid & ready_r;

  // Next-state decode: strictly IDLE -> READ -> EXEC -> WB -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ:    state_nxt_s = EXEC;
      EXEC:    state_nxt_s = WB;
      WB:      state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus handshake/completion outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      done_rd_r <= {AW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == IDLE);
      done_r  <= (state_nxt_s == WB);
      if (state_nxt_s == WB) begin
        done_rd_r <= rd_r;
      end else begin
        done_rd_r <= done_rd_r;
      end
    end
  end

  // Instruction latch; the upstream fields may change freely once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 3'b000;
      rd_r     <= {AW{1'b0}};
      rs1_r    <= {AW{1'b0}};
      rs2_r    <= {AW{1'b0}};
      imm_en_r <= 1'b0;
      imm_r    <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      op_r     <= in_op;
      rd_r     <= in_rd;
      rs1_r    <= in_rs1;
      rs2_r    <= in_rs2;
      imm_en_r <= in_imm_en;
      imm_r    <= in_imm;
    end else begin
      op_r     <= op_r;
      rd_r     <= rd_r;
      rs1_r    <= rs1_r;
      rs2_r    <= rs2_r;
      imm_en_r <= imm_en_r;
      imm_r    <= imm_r;
    end
  end

  // ALU operand/opcode registers; rf reads see contents from before any same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r  <= {DATA_W{1'b0}};
      alu_b_r  <= {DATA_W{1'b0}};
      alu_op_r <= 3'b000;
    end else if (state_r == READ) begin
      alu_a_r  <= rf_r[rs1_r];
      alu_b_r  <= imm_en_r ? imm_r : rf_r[rs2_r];
      alu_op_r <= op_r;
    end else begin
      alu_a_r  <= alu_a_r;
      alu_b_r  <= alu_b_r;
      alu_op_r <= alu_op_r;
    end
  end

  // Result and flag capture from the ALU at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r <= {DATA_W{1'b0}};
      cz_r  <= 1'b0;
      cc_r  <= 1'b0;
    end else if (state_r == EXEC) begin
      res_r <= alu_y;
      cz_r  <= alu_z;
      cc_r  <= alu_c;
    end else begin
      res_r <= res_r;
      cz_r  <= cz_r;
      cc_r  <= cc_r;
    end
  end

  // Architectural flags move only on the write-back edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_r <= 1'b0;
      flag_c_r <= 1'b0;
    end else if (state_r == WB) begin
      flag_z_r <= cz_r;
      flag_c_r <= cc_r;
    end else begin
      flag_z_r <= flag_z_r;
      flag_c_r <= flag_c_r;
    end
  end

  // Register file: write-back has priority over an external write to the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        rf_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if ((state_r == WB) && (rd_r == AW'(i))) begin
          rf_r[i] <= res_r;
        end else if (wr_en && (wr_addr == AW'(i))) begin
          rf_r[i] <= wr_data;
        end else begin
          rf_r[i] <= rf_r[i];
        end
      end
    end
  end

  assign in_ready   = ready_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_opcode = alu_op_r;
  assign done       = done_r;
  assign done_rd    = done_rd_r;
  assign done_data  = res_r;
  assign flag_z     = flag_z_r;
  assign flag_c     = flag_c_r;
  assign dbg_data   = rf_r[dbg_addr];

endmodule
